// File: rtl/cu_pkg.sv
// Shared types and constants for the control unit: opcode and ALU
// encodings, the registered control word, and its two safe default values.
package cu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_BEQ  = 4'd6,
    OP_ANDI = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_e;

  typedef struct packed {
    logic      RegWrite;
    logic      ALUSrc;
    logic      Branch;
    alu_ctrl_e ALUControl;
    logic      Illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    RegWrite: 1'b0, ALUSrc: 1'b0, Branch: 1'b0, ALUControl: ALU_ADD, Illegal: 1'b0
  };

  // Undefined or unknown opcodes behave as a NOP but are flagged.
  localparam ctrl_t CTRL_ILLEGAL = '{
    RegWrite: 1'b0, ALUSrc: 1'b0, Branch: 1'b0, ALUControl: ALU_ADD, Illegal: 1'b1
  };

  function automatic ctrl_t mk_ctrl(input logic reg_write, input logic alu_src,
                                    input logic branch, input alu_ctrl_e alu);
    ctrl_t c;
    c.RegWrite   = reg_write;
    c.ALUSrc     = alu_src;
    c.Branch     = branch;
    c.ALUControl = alu;
    c.Illegal    = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/cu_if.sv
// Opcode-in / control-out bundle of the control unit; the master drives the
// opcode, the slave (the control unit) returns the decoded controls.
interface cu_if;
  logic [3:0] opcode;
  logic       Branch;
  logic       ALUSrc;
  logic       RegWrite;
  logic [1:0] ALUControl;
  logic       Illegal;

  modport master (output opcode, input Branch, ALUSrc, RegWrite, ALUControl, Illegal);
  modport slave  (input opcode, output Branch, ALUSrc, RegWrite, ALUControl, Illegal);
endinterface

// File: rtl/cu_decode.sv
// Purely combinational opcode decoder producing one control word.
module cu_decode
  import cu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    o_ctrl = CTRL_ILLEGAL;
    case (i_opcode)
      OP_NOP:  o_ctrl = CTRL_NOP;
      OP_ADD:  o_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, ALU_ADD);
      OP_SUB:  o_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, ALU_SUB);
      OP_AND:  o_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, ALU_AND);
      OP_OR:   o_ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, ALU_OR);
      OP_ADDI: o_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_ADD);
      OP_BEQ:  o_ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, ALU_SUB);
      OP_ANDI: o_ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, ALU_AND);
      // Opcodes 8-15 and any X/Z pattern land here and never write.
      default: o_ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/cu.sv
// Control unit top: decodes the opcode and registers the control word,
// giving one cycle of latency; reset clears every output immediately.
module cu
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       Branch,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic [1:0] ALUControl,
  output logic       Illegal
);

  ctrl_t w_ctrl;
  ctrl_t r_ctrl;

  cu_decode u_decode (
    .i_opcode (opcode),
    .o_ctrl   (w_ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (rst) r_ctrl <= CTRL_NOP;
    else     r_ctrl <= w_ctrl;
  end

  assign Branch     = r_ctrl.Branch;
  assign ALUSrc     = r_ctrl.ALUSrc;
  assign RegWrite   = r_ctrl.RegWrite;
  assign ALUControl = r_ctrl.ALUControl;
  assign Illegal    = r_ctrl.Illegal;

endmodule

// File: tb/tb_cu.sv
// Table-driven bench for the control unit plus directed sequences for
// reset, latency and mid-stream reset. Control word order: RW,SRC,BR,ALU,ILL.
module tb_cu;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  cu_if bus ();

  cu dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (bus.opcode),
    .Branch     (bus.Branch),
    .ALUSrc     (bus.ALUSrc),
    .RegWrite   (bus.RegWrite),
    .ALUControl (bus.ALUControl),
    .Illegal    (bus.Illegal)
  );

  always #5 clk = ~clk;

  logic [5:0] act;
  assign act = {bus.RegWrite, bus.ALUSrc, bus.Branch, bus.ALUControl, bus.Illegal};

  typedef struct {
    logic [3:0] op;
    logic [5:0] exp;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges while opcode op is being registered.
  task automatic mid_reset(input string name, input logic [3:0] op, input logic [5:0] exp);
    bus.opcode = op;
    step();
    check({name, "_before"}, act, exp);
    #2 rst = 1'b1;
    #1 check({name, "_async_clear"}, act, 6'b0_0_0_00_0);
    rst = 1'b0;
    step();
    check({name, "_after_release"}, act, exp);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 6'b0_0_0_00_0};
    vecs[1]  = '{4'h1, 6'b1_0_0_00_0};
    vecs[2]  = '{4'h2, 6'b1_0_0_01_0};
    vecs[3]  = '{4'h3, 6'b1_0_0_10_0};
    vecs[4]  = '{4'h4, 6'b1_0_0_11_0};
    vecs[5]  = '{4'h5, 6'b1_1_0_00_0};
    vecs[6]  = '{4'h6, 6'b0_0_1_01_0};
    vecs[7]  = '{4'h7, 6'b1_1_0_10_0};
    vecs[8]  = '{4'hF, 6'b0_0_0_00_1};
    vecs[9]  = '{4'h3, 6'b1_0_0_10_0};
    vecs[10] = '{4'h8, 6'b0_0_0_00_1};
    vecs[11] = '{4'hC, 6'b0_0_0_00_1};
    vecs[12] = '{4'h5, 6'b1_1_0_00_0};
    vecs[13] = '{4'h0, 6'b0_0_0_00_0};

    // Reset with an ADD opcode waiting: outputs cleared without any edge.
    rst = 1'b1;
    bus.opcode = 4'h1;
    #2 check("reset_async", act, 6'b0_0_0_00_0);
    step();
    check("reset_hold_over_edge", act, 6'b0_0_0_00_0);
    rst = 1'b0;
    step();
    check("reset_release_add", act, 6'b1_0_0_00_0);

    // Back-to-back opcodes, one per cycle.
    for (int i = 0; i < NVEC; i++) begin
      bus.opcode = vecs[i].op;
      step();
      check($sformatf("vec%0d_op%0h", i, vecs[i].op), act, vecs[i].exp);
    end

    // Opcode changes between edges; outputs hold until the next edge.
    bus.opcode = 4'h2;
    step();
    check("latency_sub", act, 6'b1_0_0_01_0);
    #2 bus.opcode = 4'h4;
    #1 check("latency_hold", act, 6'b1_0_0_01_0);
    step();
    check("latency_or", act, 6'b1_0_0_11_0);

    mid_reset("midrst_beq", 4'h6, 6'b0_0_1_01_0);
    mid_reset("midrst_addi", 4'h5, 6'b1_1_0_00_0);

    // Unknown opcode must not produce a write or a branch.
    bus.opcode = 4'bxxxx;
    step();
    check("xop_regwrite", {5'b0, bus.RegWrite}, 6'd0);
    check("xop_branch", {5'b0, bus.Branch}, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu.md
CU -- requirements
Module: cu

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 Ports SHALL be as follows, in this order:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- opcode  input  4  instruction opcode.
- Branch  output  1  branch-taken qualifier.
- ALUSrc  output  1  ALU operand B select: 0 = register, 1 = immediate.
- RegWrite  output  1  register-file write enable.
- ALUControl  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- Illegal  output  1  opcode not in the defined set.
REQ-003 The clocking scheme SHALL be one clock (clk), with an asynchronous, active-high reset (rst).

Function
REQ-004 opcode SHALL be decoded combinationally; all outputs SHALL be registered on the rising edge of clk, giving 1-cycle latency from opcode to outputs.
REQ-005 The decode table SHALL be as follows (RegWrite/ALUSrc/Branch/ALUControl/Illegal):
- 0 NOP: 0/0/0/00/0
- 1 ADD: 1/0/0/00/0
- 2 SUB: 1/0/0/01/0
- 3 AND: 1/0/0/10/0
- 4 OR: 1/0/0/11/0
- 5 ADDI: 1/1/0/00/0
- 6 BEQ: 0/0/1/01/0
- 7 ANDI: 1/1/0/10/0
REQ-006 Opcodes 8-15 SHALL produce RegWrite=0, ALUSrc=0, Branch=0, ALUControl=00 and Illegal=1, which is safe NOP behaviour.
REQ-007 The outputs SHALL be a pure function of the opcode sampled at the previous edge; no other state is held.
REQ-008 An X or Z on opcode SHALL NOT be propagated as a write. The decoder default branch SHALL drive the same values as REQ-006.
REQ-009 When opcode changes every cycle, each output set SHALL correspond exactly to the preceding cycle's opcode, with no skipped or merged values.

Reset
REQ-010 While rst=1, all outputs SHALL be 0 immediately, without waiting for a clock edge: Branch=0, ALUSrc=0, RegWrite=0, ALUControl=00, Illegal=0.
REQ-011 At the first rising clk edge after rst deasserts, the outputs SHALL reflect the opcode present at that edge.
REQ-012 Asserting rst mid-stream SHALL clear the outputs asynchronously, even when RegWrite=1 or Branch=1 at that moment.

Structure
REQ-013 A shared package cu_pkg SHALL hold:
- an opcode enum: OP_NOP=0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_BEQ, OP_ANDI.
- an alu_ctrl enum: ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11.
- a packed struct ctrl_t {RegWrite, ALUSrc, Branch, ALUControl, Illegal}.
- the constant CTRL_NOP.
REQ-014 A single combinational sub-module, cu_decode (opcode in, ctrl_t out), SHALL implement the table. The top level cu SHALL hold only the output register and the reset.

Verification
REQ-015 Reset: assert rst with opcode=1 -> all outputs 0 immediately; deassert, then one edge -> RegWrite=1, ALUControl=00.
REQ-016 Sweep: apply opcodes 0..7, one per cycle -> each cycle's outputs match the REQ-005 row of the previous opcode (e.g. opcode 5 -> RegWrite=1, ALUSrc=1, ALUControl=00; opcode 6 -> Branch=1, ALUControl=01, RegWrite=0).
REQ-017 Illegal: opcode=4'hF -> after one edge, Illegal=1 and RegWrite=0, ALUSrc=0, Branch=0, ALUControl=00; then opcode=3 -> Illegal=0, ALUControl=10, RegWrite=1.
REQ-018 Latency: change opcode from 2 to 4 between edges -> outputs hold ALUControl=01 until the next rising edge, then show 11.
REQ-019 Mid-operation reset: drive opcode=6 (Branch=1), pulse rst between edges -> Branch drops to 0 asynchronously; after release and one edge, Branch returns to 1.
REQ-020 Unknown input: opcode=4'bxxxx -> after one edge, RegWrite=0 and Branch=0.
